// File: rtl/input_unit_rc.sv
`default_nettype none
// ============================================================================
//  Module      : input_unit_rc
//  Description : Router input unit. A DEPTH-entry circular flit FIFO with a
//                show-ahead head, plus combinational XY route computation on
//                the head flit's destination field.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_unit_rc #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40,
   parameter int X_COORD  = 0,
   parameter int Y_COORD  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                data_valid,
   output logic                full,
   input  logic                ready,
   output logic [3:0]          label,
   output logic [DATASIZE-1:0] data_out,
   output logic [WIDTH:0]      occupancy
);

   localparam logic [WIDTH:0] C_DEPTH = (WIDTH+1)'(DEPTH);
   localparam logic [1:0]     C_X     = 2'(X_COORD);
   localparam logic [1:0]     C_Y     = 2'(Y_COORD);

   // One-hot output-port requests; all ones means eject to the local port.
   localparam logic [3:0] C_LBL_NONE = 4'b0000;
   localparam logic [3:0] C_LBL_N    = 4'b0001;
   localparam logic [3:0] C_LBL_E    = 4'b0010;
   localparam logic [3:0] C_LBL_S    = 4'b0100;
   localparam logic [3:0] C_LBL_W    = 4'b1000;
   localparam logic [3:0] C_LBL_L    = 4'b1111;

   logic [DATASIZE-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH:0]      count_q,  count_d;

   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic [DATASIZE-1:0] w_head;
   logic [3:0]          w_dst;
   logic [1:0]          w_dx;
   logic [1:0]          w_dy;

   // A push while full is refused outright, even if a pop frees a slot this
   // same cycle; full is derived only from the registered count.
   assign full    = (count_q == C_DEPTH);
   assign w_empty = (count_q == '0);
   assign w_push  = data_valid & ~full;
   assign w_pop   = ready & ~w_empty;

   // Next-state pointers and count; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset discards every stored flit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; left uncleared by reset since the count masks stale data.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // Show-ahead head: no bypass path, so a new flit is seen one cycle later.
   assign w_head    = mem_q[rd_ptr_q];
   assign data_out  = w_empty ? '0 : w_head;
   assign occupancy = count_q;

   assign w_dst = w_head[DATASIZE-5 -: 4];
   assign w_dx  = w_dst[3:2];
   assign w_dy  = w_dst[1:0];

   // Dimension-ordered XY routing: resolve X first, then Y, else eject.
   always_comb begin
      label = C_LBL_NONE;
      if (!w_empty) begin
         if (w_dx > C_X) begin
            label = C_LBL_E;
         end else if (w_dx < C_X) begin
            label = C_LBL_W;
         end else if (w_dy > C_Y) begin
            label = C_LBL_S;
         end else if (w_dy < C_Y) begin
            label = C_LBL_N;
         end else begin
            label = C_LBL_L;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_input_unit_rc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_unit_rc
//  Description : Scoreboard bench for input_unit_rc at router (1,1). Accepted
//                pushes enqueue the expected flit/label; a monitor pops and
//                compares whenever a flit is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_unit_rc;

   logic        clk = 1'b0;
   logic        rst;
   logic [39:0] data_in;
   logic        data_valid;
   logic        full;
   logic        ready;
   logic [3:0]  label;
   logic [39:0] data_out;
   logic [3:0]  occupancy;

   typedef struct packed {
      logic [39:0] f;
      logic [3:0]  l;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  tdst [8];
   logic [3:0]  tlbl [8];
   logic [39:0] fl;

   input_unit_rc #(
      .DEPTH    (8),
      .WIDTH    (3),
      .DATASIZE (40),
      .X_COORD  (1),
      .Y_COORD  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .full       (full),
      .ready      (ready),
      .label      (label),
      .data_out   (data_out),
      .occupancy  (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   function automatic logic [39:0] mk(input logic [3:0] dst, input int idx);
      return {4'(idx), dst, 8'(idx * 7 + 1), 22'(idx * 4099 + 3), 2'(idx)};
   endfunction

   // One clock of stimulus; 'acc' says whether the flit is expected to be stored.
   task automatic cyc(input bit v, input logic [39:0] f, input logic [3:0] l,
                      input bit r, input bit acc);
      data_valid = v;
      data_in    = f;
      ready      = r;
      @(posedge clk);
      if (acc) sb.push_back('{f: f, l: l});
      #1;
      data_valid = 1'b0;
      ready      = 1'b0;
      data_in    = '0;
   endtask

   // Check on the falling edge, then return just after the next rising edge.
   task automatic settle();
      @(negedge clk);
   endtask

   task automatic resume();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a flit is consumed whenever ready is high on a non-empty FIFO.
   always @(negedge clk) begin
      if (ready && !rst) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {60'd0, label}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pop_data", data_out, e.f);
            chk("pop_label", label, e.l);
         end
      end
   end

   initial begin
      // Destination -> hand-computed XY label at router (1,1)
      tdst[0] = 4'b1001; tlbl[0] = 4'b0010;
      tdst[1] = 4'b0101; tlbl[1] = 4'b1111;
      tdst[2] = 4'b0100; tlbl[2] = 4'b0001;
      tdst[3] = 4'b0110; tlbl[3] = 4'b0100;
      tdst[4] = 4'b0001; tlbl[4] = 4'b1000;
      tdst[5] = 4'b1101; tlbl[5] = 4'b0010;
      tdst[6] = 4'b0000; tlbl[6] = 4'b1000;
      tdst[7] = 4'b0111; tlbl[7] = 4'b0100;

      rst = 1'b1; data_in = '0; data_valid = 1'b0; ready = 1'b0;
      repeat (2) @(posedge clk);
      settle();
      chk("rst_occ",   occupancy, 0);
      chk("rst_full",  full, 0);
      chk("rst_label", label, 0);
      chk("rst_data",  data_out, 0);
      resume();
      rst = 1'b0;

      // Single push east-bound, visible one cycle after the push edge
      fl = mk(4'b1001, 1);
      cyc(1, fl, 4'b0010, 0, 1);
      settle();
      chk("t1_label", label, 4'b0010);
      chk("t1_data",  data_out, fl);
      chk("t1_occ",   occupancy, 1);
      resume();
      cyc(0, '0, '0, 1, 0);

      // Four routing directions popped in order: L, N, S, W
      cyc(1, mk(4'b0101, 10), 4'b1111, 0, 1);
      cyc(1, mk(4'b0100, 11), 4'b0001, 0, 1);
      cyc(1, mk(4'b0110, 12), 4'b0100, 0, 1);
      cyc(1, mk(4'b0001, 13), 4'b1000, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0);

      // Fill to full, then an ignored ninth push
      for (int i = 0; i < 8; i++) cyc(1, mk(tdst[i], 20 + i), tlbl[i], 0, 1);
      settle();
      chk("fill_full", full, 1);
      chk("fill_occ",  occupancy, 8);
      resume();
      cyc(1, mk(4'b1111, 99), '0, 0, 0);
      chk("ovf_occ",  occupancy, 8);
      chk("ovf_full", full, 1);

      // Push and pop together while full: pop only, pushed flit is lost
      cyc(1, mk(4'b1010, 98), '0, 1, 0);
      chk("fpp_occ",  occupancy, 7);
      chk("fpp_full", full, 0);
      for (int i = 0; i < 7; i++) cyc(0, '0, '0, 1, 0);
      settle();
      chk("drain_label", label, 0);
      chk("drain_data",  data_out, 0);
      chk("drain_occ",   occupancy, 0);
      resume();

      // Steady state at four entries with continuous push+pop (pointers wrap)
      for (int i = 0; i < 4; i++) cyc(1, mk(tdst[i], 40 + i), tlbl[i], 0, 1);
      for (int i = 0; i < 12; i++) begin
         cyc(1, mk(tdst[(i + 4) % 8], 44 + i), tlbl[(i + 4) % 8], 1, 1);
         chk("stream_occ", occupancy, 4);
      end
      for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0);

      // Asynchronous reset between edges at occupancy five
      for (int i = 0; i < 5; i++) cyc(1, mk(tdst[i], 70 + i), tlbl[i], 0, 1);
      chk("pre_rst_occ", occupancy, 5);
      #1 rst = 1'b1;
      #1;
      chk("arst_occ",   occupancy, 0);
      chk("arst_full",  full, 0);
      chk("arst_label", label, 0);
      chk("arst_data",  data_out, 0);
      sb.delete();
      #1 rst = 1'b0;
      fl = mk(4'b0110, 60);
      cyc(1, fl, 4'b0100, 0, 1);
      chk("post_rst_label", label, 4'b0100);
      chk("post_rst_data",  data_out, fl);
      chk("post_rst_occ",   occupancy, 1);
      cyc(0, '0, '0, 1, 0);

      settle();
      chk("sb_empty",  sb.size(), 0);
      chk("final_occ", occupancy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
